// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants and instruction-memory loader state encoding
package cpu_pkg;

    localparam int INSTR_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        WORD_HI,
        WORD_LO,
        CKSUM,
        DONE,
        ERR
    } ld_state_t;

endpackage

// File: rtl/loader_xor_acc.sv
// loader_xor_acc: running XOR of accepted bytes, cleared at the start of each load
module loader_xor_acc (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] d,
    output logic [7:0] q
);

    // accumulate every enabled byte; clear wins over enable
    always_ff @(posedge clk) begin
        if (reset || clr) q <= '0;
        else if (en) q <= q ^ d;
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte-stream instruction memory loader; LOADER_CKSUM_EN adds a trailing XOR checksum byte
module imem_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               cpu_hold
);

    ld_state_t   state, state_n;
    logic [7:0]  hi;
    logic [15:0] len, widx, n_in;
    logic        accept, start_ok, last, cks_ok;

    assign accept   = in_valid && in_ready;
    assign start_ok = start && (state == IDLE || state == DONE || state == ERR);
    assign n_in     = {hi, in_data};
    assign last     = (widx + 16'd1) == len;
    assign in_ready = state inside {LEN_HI, LEN_LO, WORD_HI, WORD_LO, CKSUM};
    assign busy     = in_ready;
    assign done     = state == DONE;
    assign error    = state == ERR;
    assign cpu_hold = state != DONE;

`ifdef LOADER_CKSUM_EN
    localparam ld_state_t FIN = CKSUM;
    logic [7:0] acc;
    loader_xor_acc u_acc (
        .clk   (clk),
        .reset (reset),
        .clr   (start_ok),
        .en    (accept),
        .d     (in_data),
        .q     (acc)
    );
    assign cks_ok = acc == in_data;
`else
    localparam ld_state_t FIN = DONE;
    assign cks_ok = 1'b1;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end

    // next-state: one byte per accept, length validated before any word is written
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE, ERR: state_n = start_ok ? LEN_HI : state;
            LEN_HI:  state_n = accept ? LEN_LO : state;
            LEN_LO:  state_n = !accept ? state : n_in == 16'd0 ? FIN : n_in > 16'(DEPTH) ? ERR : WORD_HI;
            WORD_HI: state_n = accept ? WORD_LO : state;
            WORD_LO: state_n = !accept ? state : last ? FIN : WORD_HI;
            CKSUM:   state_n = !accept ? state : cks_ok ? DONE : ERR;
            default: state_n = IDLE;
        endcase
    end

    // byte capture, length/word counters and the registered write port
    always_ff @(posedge clk) begin
        if (reset) begin
            hi         <= '0;
            len        <= '0;
            widx       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= accept && state == WORD_LO;
            if (accept) hi <= in_data;
            if (accept && state == LEN_LO) len <= n_in;
            if (start_ok) widx <= '0;
            else if (accept && state == WORD_LO) widx <= widx + 16'd1;
            if (accept && state == WORD_LO) begin
                imem_addr  <= widx[ADDR_W-1:0];
                imem_wdata <= {hi, in_data};
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader; define LOADER_CKSUM_EN to exercise the checksum build
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, imem_we, busy, done, error, cpu_hold;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;

    int vectors = 0;
    int miscompares = 0;
    logic [23:0] exp_q[$];
    logic [15:0] words[$];
    logic [23:0] mon_e;

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cpu_hold   (cpu_hold)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1);
    end

    // scoreboard: every write pulse must match the oldest expected {addr,data}
    always @(negedge clk) begin
        if (imem_we) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write got addr=%h data=%h, required no write", imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== mon_e) begin
                    miscompares++;
                    $display("FAIL write got addr=%h data=%h, required addr=%h data=%h",
                             imem_addr, imem_wdata, mon_e[23:16], mon_e[15:0]);
                end
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        start    = gaps && $urandom_range(0, 3) == 0;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL byte_timeout in_ready=%b required 1 for byte %h", in_ready, b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] len, input bit gaps, input bit bad_ck);
        logic [7:0] ck;
        ck = len[15:8] ^ len[7:0];
        do_start();
        vectors++;
        if ({busy, cpu_hold, done, error} !== 4'b1100) begin
            miscompares++;
            $display("FAIL after_start got busy,hold,done,err=%b required 1100", {busy, cpu_hold, done, error});
        end
        send_byte(len[15:8], gaps);
        send_byte(len[7:0], gaps);
        if (len > 16'd256) return;
        foreach (words[i]) begin
            send_byte(words[i][15:8], gaps);
            exp_q.push_back({8'(i), words[i]});
            send_byte(words[i][7:0], gaps);
            ck ^= words[i][15:8] ^ words[i][7:0];
        end
`ifdef LOADER_CKSUM_EN
        send_byte(ck ^ {7'd0, bad_ck}, gaps);
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        vectors++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, busy, done, error, cpu_hold} !== {2'b00, 8'h00, 16'h0000, 4'b0001}) begin
            miscompares++;
            $display("FAIL reset_state got ready=%b we=%b addr=%h wdata=%h busy=%b done=%b err=%b hold=%b, required 0 0 00 0000 0 0 0 1",
                     in_ready, imem_we, imem_addr, imem_wdata, busy, done, error, cpu_hold);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, done, error, cpu_hold, in_ready} !== 5'b00010) begin
            miscompares++;
            $display("FAIL idle_after_reset got busy,done,err,hold,ready=%b required 00010", {busy, done, error, cpu_hold, in_ready});
        end
    endtask

    task automatic test_basic(input bit gaps);
        words = '{16'h1223, 16'h2345, 16'h4567, 16'h6789};
        send_frame(16'd4, gaps, 1'b0);
        @(negedge clk);
        vectors++;
        if ({done, error, cpu_hold, busy, in_ready} !== 5'b10000) begin
            miscompares++;
            $display("FAIL basic_done gaps=%0b got done,err,hold,busy,ready=%b required 10000", gaps, {done, error, cpu_hold, busy, in_ready});
        end
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL basic_writes gaps=%0b got %0d writes missing, required 0", gaps, exp_q.size());
        end
    endtask

    task automatic test_zero_len();
        words = {};
        send_frame(16'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        vectors++;
        if ({done, error, cpu_hold, busy, in_ready} !== 5'b10000) begin
            miscompares++;
            $display("FAIL zero_len got done,err,hold,busy,ready=%b required 10000", {done, error, cpu_hold, busy, in_ready});
        end
    endtask

    task automatic test_too_long();
        words = {};
        send_frame(16'h0101, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) @(negedge clk);
        vectors++;
        if ({done, error, cpu_hold, busy, in_ready} !== 5'b01100) begin
            miscompares++;
            $display("FAIL too_long got done,err,hold,busy,ready=%b required 01100", {done, error, cpu_hold, busy, in_ready});
        end
        in_valid = 1'b0;
    endtask

    task automatic test_full_depth();
        words = {};
        for (int i = 0; i < 256; i++) words.push_back(16'($urandom));
        send_frame(16'd256, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        vectors++;
        if ({done, error, cpu_hold, exp_q.size() == 0} !== 4'b1001) begin
            miscompares++;
            $display("FAIL full_depth got done,err,hold=%b pending=%0d, required 100 pending=0", {done, error, cpu_hold}, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        do_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h11, 1'b0);
        exp_q.push_back({8'h00, 16'h1122});
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if ({done, error, cpu_hold, busy, in_ready, exp_q.size() == 0} !== 6'b001001) begin
            miscompares++;
            $display("FAIL reset_mid got done,err,hold,busy,ready=%b pending=%0d, required 00100 pending=0",
                     {done, error, cpu_hold, busy, in_ready}, exp_q.size());
        end
        do_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hAB, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hCD;
        reset    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        vectors++;
        if ({done, error, cpu_hold, busy, imem_we} !== 5'b00100) begin
            miscompares++;
            $display("FAIL reset_drop_write got done,err,hold,busy,we=%b required 00100", {done, error, cpu_hold, busy, imem_we});
        end
    endtask

`ifdef LOADER_CKSUM_EN
    task automatic test_cksum();
        words = '{16'hABCD};
        send_frame(16'd1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        vectors++;
        if ({done, error, cpu_hold, exp_q.size() == 0} !== 4'b1001) begin
            miscompares++;
            $display("FAIL cksum_good got done,err,hold=%b pending=%0d, required 100 pending=0", {done, error, cpu_hold}, exp_q.size());
        end
        send_frame(16'd1, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        vectors++;
        if ({done, error, cpu_hold, in_ready, exp_q.size() == 0} !== 5'b01101) begin
            miscompares++;
            $display("FAIL cksum_bad got done,err,hold,ready=%b pending=%0d, required 0110 pending=0",
                     {done, error, cpu_hold, in_ready}, exp_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_zero_len();
        test_too_long();
        test_basic(1'b0);
        test_full_depth();
        test_reset_mid();
        test_basic(1'b0);
`ifdef LOADER_CKSUM_EN
        test_cksum();
`endif
        repeat (4) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL final_drain got %0d writes missing, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
